mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single DPI-backed physical memory port (pmem_read/pmem_write wrapper) between two requesters: instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Sits between the core and the pmem wrapper.
- Allows one outstanding transaction at a time.
- Registers the winning request, drives a req/gnt handshake downstream, and routes the response back to the owner. A watchdog counter terminates hung transactions with an error.

Parameters:
- ADDR_W, 64: address width.
- DATA_W, 64: data width; the write mask is DATA_W/8 bits.
- TIMEOUT, 256: maximum cycles spent in REQ plus RESP before the transaction is aborted with an error. Must be ≥ 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets the block.
- ifu_req  in  1  IFU read request; held stable until ifu_gnt.
- ifu_addr  in  ADDR_W  IFU read address.
- ifu_gnt  out  1  IFU request accepted this cycle.
- ifu_rvalid  out  1  IFU response valid, 1-cycle pulse.
- ifu_rdata  out  DATA_W  IFU read data.
- ifu_err  out  1  qualifies ifu_rvalid; 1 means timeout.
- lsu_req  in  1  LSU request; held stable until lsu_gnt.
- lsu_we  in  1  1 = write, 0 = read.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_wmask  in  DATA_W/8  LSU byte-enable mask.
- lsu_gnt  out  1  LSU request accepted this cycle.
- lsu_rvalid  out  1  LSU response or write-ack, 1-cycle pulse.
- lsu_rdata  out  DATA_W  LSU read data; 0 on writes.
- lsu_err  out  1  qualifies lsu_rvalid; 1 means timeout.
- mem_req  out  1  downstream request; held until mem_gnt.
- mem_we  out  1  downstream write enable.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_wmask  out  DATA_W/8  downstream mask; 0 on reads.
- mem_gnt  in  1  memory accepted mem_req.
- mem_rvalid  in  1  memory response / write-ack.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset:
  - State goes to IDLE; owner, counter and all registered mem_* fields clear to 0.
  - All outputs are 0 while rst==0 and in the first IDLE cycle after reset.
  - Reset mid-transaction abandons the transaction; no rvalid is issued.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any *_req is high, select a winner (priority below).
  - The winner's *_gnt is asserted combinationally in the same cycle.
  - At the clock edge: latch the winner's addr/we/wdata/wmask into the mem_* registers (IFU: we=0, wmask=0, wdata=0), record the owner, clear the counter, and go to REQ.
  - Only one gnt may be high in any cycle.
- REQ:
  - mem_req=1 with the latched fields.
  - mem_gnt=1 at an edge: go to RESP and drop mem_req from the next cycle.
  - mem_gnt and mem_rvalid both high in the same cycle counts as grant plus response: the response is delivered this cycle and the next state is IDLE.
- RESP:
  - On mem_rvalid=1, pulse owner_rvalid combinationally in the same cycle, with owner_rdata = mem_rdata (0 for LSU writes) and owner_err=0. Next state is IDLE.
  - mem_rvalid in IDLE or REQ (without gnt) is ignored.
- Fixed priority (default): LSU beats IFU when both request in IDLE. IFU waits with its request held.
- Minimum latency:
  - Request at cycle 0: gnt at cycle 0, mem_req at cycle 1.
  - With mem_gnt at cycle 1 and mem_rvalid at cycle 2, rvalid reaches the requester at cycle 2.
  - Back-to-back: a new gnt is possible in the first IDLE cycle after rvalid. Sustained throughput is one transaction per 3 cycles.
- Watchdog:
  - The counter increments every cycle in REQ or RESP and saturates.
  - When counter == TIMEOUT-1 and no completing response arrives this cycle: pulse owner_rvalid with owner_err=1 and rdata=0, drop mem_req, and go to IDLE.
  - A later stray mem_rvalid is ignored.
- *_rvalid and *_err are 0 outside their owner's completion cycle.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A last-owner register (reset value IFU) is updated on every grant.
  - On simultaneous requests, the requester that was not last granted wins.
  - A single requester always wins regardless of history.
- Undefined: fixed LSU priority; no last-owner register is instantiated.

Test Plan:
- Single IFU read: ifu_req=1, addr=0x80000000; mem_gnt at cycle 1, mem_rvalid at cycle 2 with rdata=0x00100073 → ifu_gnt at cycle 0; mem_req=1 and mem_addr=0x80000000 at cycle 1 only; ifu_rvalid=1 and ifu_rdata=0x00100073 at cycle 2; lsu_rvalid stays 0.
- LSU write: we=1, addr=0x80001000, wdata=0x1234567887654321, wmask=0xFF; memory acks with mem_gnt and mem_rvalid in the same cycle → mem_we=1 and mem_wmask=0xFF; lsu_rvalid in the same cycle with lsu_rdata=0; state returns to IDLE.
- Simultaneous IFU and LSU requests, four consecutive transactions (all requests held) → default build: LSU granted on every one, IFU never while lsu_req is held. With MEM_ARB_ROUND_ROBIN_EN: grant order is LSU, IFU, LSU, IFU (last-owner resets to IFU).
- Timeout with TIMEOUT=8: mem_gnt is never asserted → mem_req held 7 cycles; lsu_rvalid=1, lsu_err=1, lsu_rdata=0 in the 7th cycle of REQ; back to IDLE; a mem_rvalid injected 2 cycles later produces no output.
- Reset mid-RESP: drive rst=0 for 1 cycle while waiting for rvalid → all outputs 0; FSM in IDLE; a subsequent mem_rvalid is ignored; a new IFU request is granted normally.
- Stall in REQ: hold mem_gnt=0 for 5 cycles → mem_req and mem_addr remain stable, and no gnt is issued to the other requester in the meantime.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (IFU/LSU) arbiter in front of a single req/gnt memory port, one outstanding transaction.
// Optional `MEM_ARB_ROUND_ROBIN_EN swaps fixed LSU priority for alternating priority.
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_gnt,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;
  // Counter holds cycles already spent in REQ/RESP, so the abort fires on the cycle it reaches TIMEOUT-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                armed_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;

  logic win_ifu, win_lsu, grant_ok, take;
  logic complete, timeout;
  logic [DATA_W-1:0] resp_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e last_q;

  always_comb begin
    win_lsu = lsu_req && (!ifu_req || (last_q == OWN_IFU));
    win_ifu = ifu_req && !win_lsu;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= OWN_IFU;
    end else if (take) begin
      last_q <= win_lsu ? OWN_LSU : OWN_IFU;
    end
  end
`else
  always_comb begin
    win_lsu = lsu_req;
    win_ifu = ifu_req && !lsu_req;
  end
`endif

  // No grant in the first IDLE cycle after reset: armed_q rises one edge after reset releases.
  assign grant_ok = rst && armed_q && (state_q == IDLE);
  assign take     = grant_ok && (ifu_req || lsu_req);
  assign complete = ((state_q == REQ) && mem_gnt && mem_rvalid) ||
                    ((state_q == RESP) && mem_rvalid);
  assign timeout  = (state_q != IDLE) && (cnt_q == CNT_LAST) && !complete;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take) state_d = REQ;
      REQ: begin
        if (complete || timeout) state_d = IDLE;
        else if (mem_gnt)        state_d = RESP;
      end
      RESP: if (complete || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the mem_* fields are ordinary flops, not a memory array, so resetting them costs nothing and keeps outputs defined.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= OWN_IFU;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      armed_q <= 1'b1;
      if (take) begin
        cnt_q <= '0;
        if (win_lsu) begin
          owner_q     <= OWN_LSU;
          mem_we_q    <= lsu_we;
          mem_addr_q  <= lsu_addr;
          mem_wdata_q <= lsu_wdata;
          mem_wmask_q <= lsu_we ? lsu_wmask : '0;
        end else begin
          owner_q     <= OWN_IFU;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= ifu_addr;
          mem_wdata_q <= '0;
          mem_wmask_q <= '0;
        end
      end else if ((state_q != IDLE) && (cnt_q != CNT_SAT)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    ifu_gnt    = 1'b0;
    lsu_gnt    = 1'b0;
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    ifu_err    = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    lsu_err    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    resp_data  = '0;
    if (rst) begin
      if (grant_ok) begin
        ifu_gnt = win_ifu;
        lsu_gnt = win_lsu;
      end
      mem_req   = (state_q == REQ);
      mem_we    = mem_we_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      mem_wmask = mem_wmask_q;
      if (complete && !mem_we_q) resp_data = mem_rdata;
      if (complete || timeout) begin
        if (owner_q == OWN_LSU) begin
          lsu_rvalid = 1'b1;
          lsu_err    = timeout;
          lsu_rdata  = resp_data;
        end else begin
          ifu_rvalid = 1'b1;
          ifu_err    = timeout;
          ifu_rdata  = resp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int TO = 8;

  typedef struct {
    bit          lsu;
    bit          err;
    logic [63:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ifu_req, ifu_gnt, ifu_rvalid, ifu_err;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int    n_pass  = 0;
  int    n_total = 0;
  resp_t exp_q[$];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  function automatic logic any_out();
    return |{ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err, lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wmask};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; ifu_req = 1'b1; lsu_req = 1'b1;
    step();
    smp(); check1("reset_outputs_zero", any_out(), 1'b0);
    ifu_req = 1'b0; lsu_req = 1'b0;
    step();
    rst = 1'b1;
    smp(); check1("first_idle_outputs_zero", any_out(), 1'b0);
    step();
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    resp_t e;
    if (ifu_rvalid || lsu_rvalid) begin
      if (exp_q.size() == 0) begin
        check64("stray_rvalid", {62'd0, ifu_rvalid, lsu_rvalid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check64("resp_owner", {62'd0, ifu_rvalid, lsu_rvalid}, e.lsu ? 64'd1 : 64'd2);
        check1("resp_err", e.lsu ? lsu_err : ifu_err, e.err);
        check64("resp_rdata", e.lsu ? lsu_rdata : ifu_rdata, e.rdata);
      end
    end else if (ifu_err || lsu_err) begin
      check64("err_without_rvalid", {62'd0, ifu_err, lsu_err}, 64'd0);
    end
  end

  initial begin
    rst = 1'b0;
    ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    do_reset();

    // Single IFU read at minimum latency.
    ifu_req = 1'b1; ifu_addr = 64'h8000_0000;
    smp(); check1("ifu_gnt_c0", ifu_gnt, 1'b1); check1("lsu_gnt_c0", lsu_gnt, 1'b0);
    check1("mem_req_c0", mem_req, 1'b0);
    step(); ifu_req = 1'b0; mem_gnt = 1'b1;
    smp(); check1("mem_req_c1", mem_req, 1'b1); check64("mem_addr_c1", mem_addr, 64'h8000_0000);
    check1("mem_we_ifu", mem_we, 1'b0); check64("mem_wmask_ifu", 64'(mem_wmask), 64'd0);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0010_0073;
    exp_q.push_back('{lsu: 1'b0, err: 1'b0, rdata: 64'h0010_0073});
    smp(); check1("mem_req_c2", mem_req, 1'b0);
    step(); mem_rvalid = 1'b0;

    // LSU write acked with gnt and rvalid together.
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_1000;
    lsu_wdata = 64'h1234_5678_8765_4321; lsu_wmask = 8'hFF;
    smp(); check1("lsu_wr_gnt", lsu_gnt, 1'b1); check1("lsu_wr_ifu_gnt", ifu_gnt, 1'b0);
    step(); lsu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
    exp_q.push_back('{lsu: 1'b1, err: 1'b0, rdata: 64'd0});
    smp(); check1("lsu_wr_mem_req", mem_req, 1'b1); check1("lsu_wr_mem_we", mem_we, 1'b1);
    check64("lsu_wr_mem_wmask", 64'(mem_wmask), 64'hFF);
    check64("lsu_wr_mem_addr", mem_addr, 64'h8000_1000);
    check64("lsu_wr_mem_wdata", mem_wdata, 64'h1234_5678_8765_4321);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
    smp(); check1("lsu_wr_back_idle", mem_req, 1'b0);

    // Four transactions with both requesters held.
    do_reset();
    ifu_req = 1'b1; ifu_addr = 64'h8000_2000;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_3000; lsu_wdata = 64'hFFFF; lsu_wmask = 8'h0F;
    for (int t = 0; t < 4; t++) begin
      bit exp_lsu;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_lsu = (t % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      smp(); check1("arb_lsu_gnt", lsu_gnt, exp_lsu); check1("arb_ifu_gnt", ifu_gnt, !exp_lsu);
      step(); mem_gnt = 1'b1;
      smp(); check1("arb_mem_req", mem_req, 1'b1);
      check64("arb_mem_addr", mem_addr, exp_lsu ? 64'h8000_3000 : 64'h8000_2000);
      check64("arb_rd_wmask", 64'(mem_wmask), 64'd0);
      check1("arb_no_gnt_req", ifu_gnt | lsu_gnt, 1'b0);
      step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hA0 + 64'(t);
      exp_q.push_back('{lsu: exp_lsu, err: 1'b0, rdata: 64'hA0 + 64'(t)});
      smp(); check1("arb_no_gnt_resp", ifu_gnt | lsu_gnt, 1'b0);
      step(); mem_rvalid = 1'b0;
    end
    ifu_req = 1'b0; lsu_req = 1'b0;
    step();

    // Watchdog: no mem_gnt ever; abort in the 7th REQ cycle.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_4000; lsu_wmask = 8'hFF;
    smp(); check1("to_gnt", lsu_gnt, 1'b1);
    step(); lsu_req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 7) begin
        mem_rdata = 64'hBAD;
        exp_q.push_back('{lsu: 1'b1, err: 1'b1, rdata: 64'd0});
      end
      smp(); check1("to_mem_req_held", mem_req, 1'b1);
      step();
    end
    smp(); check1("to_mem_req_dropped", mem_req, 1'b0);
    step(); mem_rvalid = 1'b1; mem_rdata = 64'h55;
    smp(); check1("to_stray_lsu", lsu_rvalid, 1'b0); check1("to_stray_ifu", ifu_rvalid, 1'b0);
    step(); mem_rvalid = 1'b0;

    // Stall in REQ for 5 cycles while IFU waits; response lands on the last allowed cycle.
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_5000; lsu_wdata = 64'hCAFE; lsu_wmask = 8'h3C;
    ifu_req = 1'b1; ifu_addr = 64'h8000_6000;
    smp(); check1("stall_lsu_gnt", lsu_gnt, 1'b1); check1("stall_ifu_gnt_c0", ifu_gnt, 1'b0);
    step(); lsu_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      smp(); check1("stall_mem_req", mem_req, 1'b1);
      check64("stall_mem_addr", mem_addr, 64'h8000_5000);
      check1("stall_ifu_gnt", ifu_gnt, 1'b0);
      step();
    end
    mem_gnt = 1'b1;
    smp(); check1("stall_mem_req_c6", mem_req, 1'b1);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77;
    exp_q.push_back('{lsu: 1'b1, err: 1'b0, rdata: 64'd0});
    smp(); check1("stall_ifu_gnt_resp", ifu_gnt, 1'b0);
    step(); mem_rvalid = 1'b0;
    smp(); check1("stall_ifu_gnt_idle", ifu_gnt, 1'b1); check1("stall_lsu_gnt_idle", lsu_gnt, 1'b0);
    step(); ifu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h99;
    exp_q.push_back('{lsu: 1'b0, err: 1'b0, rdata: 64'h99});
    smp(); check64("stall_ifu_mem_addr", mem_addr, 64'h8000_6000); check1("stall_ifu_mem_we", mem_we, 1'b0);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b0;

    // Reset while waiting in RESP.
    ifu_req = 1'b1; ifu_addr = 64'h8000_7000;
    smp(); check1("rst_ifu_gnt", ifu_gnt, 1'b1);
    step(); ifu_req = 1'b0; mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0;
    smp(); check1("rst_in_resp", mem_req, 1'b0);
    step(); rst = 1'b0; lsu_req = 1'b1;
    smp(); check1("rst_mid_outputs_zero", any_out(), 1'b0);
    step(); rst = 1'b1; lsu_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h66;
    smp(); check1("rst_after_outputs_zero", any_out(), 1'b0);
    step(); mem_rvalid = 1'b0; ifu_req = 1'b1; ifu_addr = 64'h8000_8000;
    smp(); check1("rst_new_ifu_gnt", ifu_gnt, 1'b1);
    step(); ifu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h1234;
    exp_q.push_back('{lsu: 1'b0, err: 1'b0, rdata: 64'h1234});
    smp(); check64("rst_new_mem_addr", mem_addr, 64'h8000_8000);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();
    smp();

    check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
